// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the ALU arbiter slice.
// Contents: FSM state encoding, ALU opcode width, default datapath width.
// No ports; imported by rr_pick and alu_arbiter.
package alu_arb_pkg;

  localparam int ALU_OPW = 3;
  localparam int DEF_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational grant selection among NREQ requesters.
// Ports: req (request vector), last (previous winner, round-robin build only),
//        gnt (one-hot grant), gnt_idx (binary index of the grant).
// Build option ALU_ARB_FIXED_PRIO_EN: lowest index wins and the last input is removed.
module rr_pick
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic [IDW-1:0]  last,
`endif
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Scan from the top down so the lowest set index is the final assignment.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt     = '0;
        gnt[i]  = 1'b1;
        gnt_idx = IDW'(i);
      end
    end
  end
`else
  logic found;

  // Search starts one past the previous winner and wraps; last is always < NREQ,
  // so a single conditional subtraction is enough for the modulo.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IDW'(idx);
      end
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU among NREQ requesters.
// Ports: clk/rst (sync active-high), req_valid/req_ready/req_a/req_b/req_op (per-requester
//        commands), rsp_valid/rsp_ready/rsp_r/rsp_id (shared response), alu_a/alu_b/alu_op/alu_r
//        (ALU connection), busy. Build option ALU_ARB_FIXED_PRIO_EN selects fixed priority.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = DEF_W,
  parameter int IDW  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*W-1:0]       req_a,
  input  logic [NREQ*W-1:0]       req_b,
  input  logic [NREQ*ALU_OPW-1:0] req_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [W-1:0]            rsp_r,
  output logic [IDW-1:0]          rsp_id,
  output logic [W-1:0]            alu_a,
  output logic [W-1:0]            alu_b,
  output logic [ALU_OPW-1:0]      alu_op,
  input  logic [W-1:0]            alu_r,
  output logic                    busy
);

  state_t               state;
  state_t               nxt_state;
  logic [W-1:0]         opa_q;
  logic [W-1:0]         opb_q;
  logic [ALU_OPW-1:0]   op_q;
  logic [IDW-1:0]       id_q;
  logic [NREQ-1:0]      gnt;
  logic [IDW-1:0]       gnt_idx;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]       last_q;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req     (req_valid),
`ifndef ALU_ARB_FIXED_PRIO_EN
    .last    (last_q),
`endif
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Operand registers feed the ALU directly: they only change on accept, so the
  // ALU inputs stay quiet in IDLE and RESP and are stable through EXEC.
  assign alu_a  = opa_q;
  assign alu_b  = opb_q;
  assign alu_op = op_q;
  assign rsp_id = id_q;

  always_comb begin
    nxt_state = state;
    req_ready = '0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst so no handshake completes in a cycle whose state update is discarded.
        if (!rst) req_ready = gnt;
        if (|req_valid) nxt_state = EXEC;
      end
      EXEC: begin
        busy      = 1'b1;
        nxt_state = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      opa_q  <= '0;
      opb_q  <= '0;
      op_q   <= '0;
      id_q   <= '0;
      rsp_r  <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      // Pointing at the top requester makes requester 0 the first winner.
      last_q <= IDW'(NREQ - 1);
`endif
    end else begin
      state <= nxt_state;
      if (state == IDLE && |req_valid) begin
        opa_q <= req_a[int'(gnt_idx)*W +: W];
        opb_q <= req_b[int'(gnt_idx)*W +: W];
        op_q  <= req_op[int'(gnt_idx)*ALU_OPW +: ALU_OPW];
        id_q  <= gnt_idx;
      end
      if (state == EXEC) rsp_r <= alu_r;
`ifndef ALU_ARB_FIXED_PRIO_EN
      // Pointer advances only once the response is consumed.
      if (state == RESP && rsp_ready) last_q <= id_q;
`endif
    end
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 8-bit ALU (module ALU: A, B, Op -> R) among NREQ requesters.
- Each requester issues an (A, B, Op) command over a valid/ready handshake.
- The block picks one requester round-robin, drives the ALU from registered operands and captures R.
- It returns the result with the requester ID on a single shared response channel, then accepts the next command.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 8, operand/result width; must match ALU
- IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester command valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_a  in  NREQ*W  operand A, requester i at bits [i*W +: W]
- req_b  in  NREQ*W  operand B, same packing
- req_op  in  NREQ*3  ALU opcode, requester i at [i*3 +: 3]
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_r  out  W  ALU result
- rsp_id  out  IDW  index of requester that owns rsp_r
- alu_a  out  W  to ALU.A
- alu_b  out  W  to ALU.B
- alu_op  out  3  to ALU.Op
- alu_r  in  W  from ALU.R
- busy  out  1  high in EXEC or RESP

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; req_ready=0, rsp_valid=0, rsp_r=0, rsp_id=0, alu_a/alu_b/alu_op=0, busy=0.
  - Round-robin pointer last=NREQ-1, so requester 0 wins first.
  - Reset mid-operation discards any latched command or pending result; no response is emitted.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid, the winner g is the first set bit scanning last+1, last+2, ... modulo NREQ.
  - req_ready[g]=1 combinationally in the same cycle; the handshake completes there.
  - At the posedge: latch req_a/b/op[g] into operand regs, latch g into id reg, go to EXEC.
  - No valid: stay in IDLE, req_ready=0.
- EXEC: alu_a/alu_b/alu_op are driven from the operand regs (stable for the whole cycle). At the posedge: rsp_r<=alu_r, go to RESP.
- RESP:
  - rsp_valid=1; rsp_r and rsp_id held stable until the handshake.
  - rsp_valid & rsp_ready at the posedge -> last<=id, go to IDLE.
  - rsp_ready already high when rsp_valid rises completes in that same cycle.
- Latency and throughput:
  - Accept cycle N -> rsp_valid first high in cycle N+2.
  - Maximum throughput is one command per 3 cycles.
- req_ready is 0 in EXEC and RESP; new requests wait.
- Requesters must hold valid and payload stable until ready; the block does not check this.
- Op is opaque: passed through unmodified. Result is exactly W bits; no carry or flag is generated here.
- alu_* outputs hold their last values in IDLE and RESP (no toggling).

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the round-robin pointer is removed.
- Undefined (default): round-robin as above.
- Handshake and latency are identical in both builds.

Decomposition:
- Package alu_arb_pkg:
  - state enum (IDLE=2'd0, EXEC=2'd1, RESP=2'd2)
  - ALU_OPW=3
  - default W=8
- Sub-module rr_pick:
  - Inputs: request vector, last pointer.
  - Outputs: one-hot grant, grant index.
  - Purely combinational; under ALU_ARB_FIXED_PRIO_EN it reduces to a priority encoder.

Test Plan:
- Single request: req0 A=8'h6A, B=8'h3B, Op=0..7 sequentially, rsp_ready=1.
  - Each: req_ready[0] in the accept cycle, rsp_valid 2 cycles later.
  - rsp_id=0; rsp_r equals the ALU output for that op.
- All four valid continuously, rsp_ready=1: grant order 0,1,2,3,0.
  - Each rsp_id matches; one response every 3 cycles.
  - With ALU_ARB_FIXED_PRIO_EN: order 0,0,0,... (req0 held valid).
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises.
  - rsp_r/rsp_id stable; req_ready all 0; req1 waiting is not accepted until rsp_ready=1.
- Reset mid-operation: assert rst while in EXEC.
  - Next cycle: all outputs 0, no response.
  - Req2 and req0 both valid after reset: req0 granted first.
- Sparse requests: only req3 valid, then only req1.
  - Pointer wraps; req1 granted immediately; no idle cycles beyond the 3-cycle minimum.
